// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master, fixed-length header+payload frames, parameterised mode and clock divider
module spi_master #(
    parameter int HEADER_WIDTH  = 16,
    parameter int PAYLOAD_WIDTH = 128,
    parameter int TOTAL_WIDTH   = HEADER_WIDTH + PAYLOAD_WIDTH,
    parameter int MODE          = 0,
    parameter int CLK_DIV       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TOTAL_WIDTH-1:0] tx_data,
    input  logic                   tx_start,
    output logic                   tx_ready,
    output logic [TOTAL_WIDTH-1:0] rx_data,
    output logic                   rx_header_valid,
    output logic                   rx_valid,
    output logic                   spi_clk,
    output logic                   spi_cs_n,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);
    localparam logic CPOL = ((MODE / 2) % 2) == 1;
    localparam logic CPHA = (MODE % 2) == 1;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = ($clog2(2 * TOTAL_WIDTH + 1) > 10) ? $clog2(2 * TOTAL_WIDTH + 1) : 10;
    localparam int BW = ($clog2(TOTAL_WIDTH + 1) > 9) ? $clog2(TOTAL_WIDTH + 1) : 9;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * TOTAL_WIDTH - 1);
    localparam logic [BW-1:0] HDR_LAST  = BW'(HEADER_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        GAP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DW-1:0]          div_cnt;
    logic [EW-1:0]          edge_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [TOTAL_WIDTH-1:0] tx_shift;
    logic [TOTAL_WIDTH-1:0] rx_shift;
    logic                   phase_end;
    logic                   edge_tick;
    logic                   leading;
    logic                   trailing;
    logic                   sample;
    logic                   shift;

    assign tx_ready = (state == IDLE);
    assign spi_cs_n = (state == IDLE) || (state == GAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every non-idle state lasts a whole number of CLK_DIV-cycle phases;
    // in TRANSFER each phase ends with one SCLK edge.
    always_comb begin
        state_next = state;
        phase_end  = (div_cnt == DIV_LAST);
        edge_tick  = 1'b0;
        leading    = 1'b0;
        trailing   = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_next = TRANSFER;
                end
            end
            TRANSFER: begin
                if (phase_end) begin
                    edge_tick = 1'b1;
                    if (edge_cnt == EDGE_LAST) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        leading  = edge_tick && !edge_cnt[0];
        trailing = edge_tick && edge_cnt[0];
        if (CPHA) begin
            sample = trailing;
            shift  = leading;
        end else begin
            sample = leading;
            shift  = trailing && (edge_cnt != EDGE_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt         <= '0;
            edge_cnt        <= '0;
            bit_cnt         <= '0;
            tx_shift        <= '0;
            rx_shift        <= '0;
            rx_data         <= '0;
            rx_valid        <= 1'b0;
            rx_header_valid <= 1'b0;
            spi_clk         <= CPOL;
            spi_mosi        <= 1'b0;
        end else begin
            rx_valid        <= 1'b0;
            rx_header_valid <= 1'b0;
            if (state == IDLE) begin
                div_cnt  <= '0;
                edge_cnt <= '0;
                bit_cnt  <= '0;
                spi_clk  <= CPOL;
                spi_mosi <= 1'b0;
                if (tx_start) begin
                    // CPHA=0 presents the MSB before the first edge, so it leaves the shifter now
                    tx_shift <= CPHA ? tx_data : (tx_data << 1);
                    spi_mosi <= CPHA ? 1'b0 : tx_data[TOTAL_WIDTH-1];
                    rx_shift <= '0;
                end
            end else begin
                div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
                if (edge_tick) begin
                    spi_clk  <= ~spi_clk;
                    edge_cnt <= edge_cnt + 1'b1;
                end
                if (sample) begin
                    rx_shift <= {rx_shift[TOTAL_WIDTH-2:0], spi_miso};
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == HDR_LAST) begin
                        rx_header_valid <= 1'b1;
                    end
                end
                if (shift) begin
                    spi_mosi <= tx_shift[TOTAL_WIDTH-1];
                    tx_shift <= {tx_shift[TOTAL_WIDTH-2:0], 1'b0};
                end
                if (state == HOLD && phase_end) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
                if (state == GAP) begin
                    spi_mosi <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master, all four SPI modes side by side
module tb_spi_master;
    localparam int HW   = 16;
    localparam int TW   = 144;
    localparam int CD   = 2;
    localparam int BUSY = (3 + 2 * TW) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [TW-1:0] tx_data;
    logic [3:0]    tx_ready;
    logic [3:0]    rx_hv;
    logic [3:0]    rx_valid;
    logic [3:0]    spi_clk;
    logic [3:0]    cs_n;
    logic [3:0]    mosi;
    logic          miso3;
    logic [TW-1:0] rx_data [4];

    int checks = 0;
    int errors = 0;
    bit b2b    = 1'b0;

    logic [TW-1:0] exp_q [4][$];
    logic [TW-1:0] slave_q [$];
    logic [TW-1:0] slave_word;
    int            slave_idx;

    always #5 clk = ~clk;

    // Instances 0-2 loop MOSI back to MISO; instance 3 talks to a slave model
    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master #(
            .HEADER_WIDTH (HW),
            .PAYLOAD_WIDTH(TW - HW),
            .MODE         (g),
            .CLK_DIV      (CD)
        ) dut (
            .clk            (clk),
            .rst            (rst),
            .tx_data        (tx_data),
            .tx_start       (tx_start),
            .tx_ready       (tx_ready[g]),
            .rx_data        (rx_data[g]),
            .rx_header_valid(rx_hv[g]),
            .rx_valid       (rx_valid[g]),
            .spi_clk        (spi_clk[g]),
            .spi_cs_n       (cs_n[g]),
            .spi_mosi       (mosi[g]),
            .spi_miso       ((g == 3) ? miso3 : mosi[g])
        );
    end

    function automatic logic cpol(input int m);
        return m >= 2;
    endfunction

    function automatic logic cpha(input int m);
        return (m % 2) == 1;
    endfunction

    function automatic logic [TW-1:0] rand_word();
        logic [TW-1:0] w;
        w = '0;
        for (int i = 0; i < TW; i += 32) w = {w[TW-33:0], 32'($urandom())};
        return w;
    endfunction

    task automatic check(input string name, input int m, input logic [TW-1:0] act,
                         input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, m, act, exp);
        end
    endtask

    // Mode-3 slave: new bit on every leading (falling) SCLK edge, MSB first
    initial miso3 = 1'b0;
    always @(negedge cs_n[3]) begin
        slave_word = (slave_q.size() > 0) ? slave_q.pop_front() : '0;
        slave_idx  = 0;
    end
    always @(negedge spi_clk[3]) begin
        if (!cs_n[3] && slave_idx < TW) begin
            miso3 = slave_word[TW-1-slave_idx];
            slave_idx++;
        end
    end

    int   edges [4];
    int   hv_cnt [4];
    int   busy [4];
    int   hi_run [4];
    logic prev_clk [4];
    logic prev_cs [4];
    logic prev_rdy [4];

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rst) begin
                edges[m]    = 0;
                hv_cnt[m]   = 0;
                busy[m]     = 0;
                hi_run[m]   = 0;
                prev_clk[m] = cpol(m);
                prev_cs[m]  = 1'b1;
                prev_rdy[m] = 1'b1;
            end else begin
                if (!cs_n[m] && prev_cs[m]) begin
                    if (b2b) check("b2b_cs_high_cycles", m, hi_run[m], CD + 1);
                    if (!cpha(m) && m != 3 && exp_q[m].size() > 0) begin
                        logic [TW-1:0] front;
                        front = exp_q[m][0];
                        check("setup_mosi_msb", m, mosi[m], front[TW-1]);
                    end
                    edges[m]  = 0;
                    hv_cnt[m] = 0;
                end
                if (spi_clk[m] != prev_clk[m]) edges[m]++;
                if (rx_hv[m]) begin
                    hv_cnt[m]++;
                    check("hdr_pulse_edge", m, edges[m], cpha(m) ? 2 * HW : 2 * HW - 1);
                end
                if (rx_valid[m]) begin
                    if (exp_q[m].size() == 0) check("unexpected_rx_valid", m, 1, 0);
                    else check("rx_data", m, rx_data[m], exp_q[m].pop_front());
                end
                if (cs_n[m] && !prev_cs[m]) begin
                    check("sclk_edges", m, edges[m], 2 * TW);
                    check("hdr_pulses", m, hv_cnt[m], 1);
                end
                hi_run[m] = cs_n[m] ? hi_run[m] + 1 : 0;
                if (!tx_ready[m]) begin
                    busy[m]++;
                end else begin
                    if (!prev_rdy[m]) check("busy_cycles", m, busy[m], BUSY);
                    busy[m] = 0;
                    check("idle_cs_n", m, cs_n[m], 1);
                    check("idle_sclk", m, spi_clk[m], cpol(m));
                    check("idle_mosi", m, mosi[m], 0);
                end
                prev_clk[m] = spi_clk[m];
                prev_cs[m]  = cs_n[m];
                prev_rdy[m] = tx_ready[m];
            end
        end
    end

    task automatic send(input logic [TW-1:0] d, input logic [TW-1:0] s, input bit hold);
        int n;
        n = 0;
        tx_data = d;
        while (tx_ready[0] !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("ready_timeout", 0, n, 0);
        for (int m = 0; m < 4; m++) exp_q[m].push_back((m == 3) ? s : d);
        slave_q.push_back(s);
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_start = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] d_hdr;
        logic [TW-1:0] d_ends;
        logic [TW-1:0] d_ff00;
        int            n;
        d_hdr    = {16'hA5A5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        d_ends   = {1'b1, {(TW - 2){1'b0}}, 1'b1};
        d_ff00   = {{4{32'hFFFF_0000}}, 16'hFFFF};
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            check("rst_tx_ready", m, tx_ready[m], 1);
            check("rst_cs_n", m, cs_n[m], 1);
            check("rst_sclk", m, spi_clk[m], cpol(m));
            check("rst_mosi", m, mosi[m], 0);
            check("rst_rx_data", m, rx_data[m], 0);
            check("rst_rx_valid", m, rx_valid[m], 0);
            check("rst_rx_hdr_valid", m, rx_hv[m], 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(d_hdr, d_ff00, 1'b0);
        send(d_ends, d_ff00, 1'b0);
        for (int i = 0; i < 3; i++) send(rand_word(), rand_word(), 1'b0);

        // Start request during TRANSFER must be ignored
        send(rand_word(), rand_word(), 1'b0);
        repeat (100) @(posedge clk);
        #1;
        tx_data  = rand_word();
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;

        // Reset around bit 70 aborts the frame silently
        send(rand_word(), rand_word(), 1'b0);
        repeat (281) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int m = 0; m < 4; m++) exp_q[m].delete();
        slave_q.delete();
        @(posedge clk);
        #1;
        check("abort_cs_n", 0, cs_n, 4'hF);
        check("abort_sclk", 0, spi_clk, 4'b1100);
        check("abort_tx_ready", 0, tx_ready, 4'hF);
        check("abort_rx_valid", 0, rx_valid, 4'h0);
        rst = 1'b0;
        send(rand_word(), rand_word(), 1'b0);

        // tx_start held high: back-to-back frames
        send(rand_word(), rand_word(), 1'b1);
        @(negedge clk);
        #1;
        b2b = 1'b1;
        send(rand_word(), rand_word(), 1'b1);
        send(rand_word(), rand_word(), 1'b0);
        @(negedge clk);
        #1;
        b2b = 1'b0;

        n = 0;
        while ((tx_ready !== 4'hF || exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
                + exp_q[3].size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) check("drain_queue_empty", m, exp_q[m].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
